// File: rtl/reg_to_axi_master.sv
// Bridge from a reg-bus initiator to a single-beat AXI4 master port.
// One transaction in flight at a time. Each write issues AW and W together.
// Each read issues AR and takes back one R beat. The reg initiator sees a
// one-cycle ready pulse that carries rdata and error.
module reg_to_axi_master #(
    parameter int unsigned           AxiAddrWidth = 32,
    parameter int unsigned           AxiDataWidth = 64,
    parameter int unsigned           RegDataWidth = 32,
    parameter int unsigned           AxiIdWidth   = 4,
    parameter logic [AxiIdWidth-1:0] AxiId        = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    // reg request / response
    input  logic [AxiAddrWidth-1:0]     reg_addr_i,
    input  logic                        reg_write_i,
    input  logic [RegDataWidth-1:0]     reg_wdata_i,
    input  logic [RegDataWidth/8-1:0]   reg_wstrb_i,
    input  logic                        reg_valid_i,
    output logic [RegDataWidth-1:0]     reg_rdata_o,
    output logic                        reg_error_o,
    output logic                        reg_ready_o,
    // AW channel
    output logic [AxiIdWidth-1:0]       aw_id_o,
    output logic [AxiAddrWidth-1:0]     aw_addr_o,
    output logic [7:0]                  aw_len_o,
    output logic [2:0]                  aw_size_o,
    output logic [1:0]                  aw_burst_o,
    output logic                        aw_lock_o,
    output logic [3:0]                  aw_cache_o,
    output logic [2:0]                  aw_prot_o,
    output logic [3:0]                  aw_qos_o,
    output logic [3:0]                  aw_region_o,
    output logic [5:0]                  aw_atop_o,
    output logic                        aw_user_o,
    output logic                        aw_valid_o,
    input  logic                        aw_ready_i,
    // W channel
    output logic [AxiDataWidth-1:0]     w_data_o,
    output logic [AxiDataWidth/8-1:0]   w_strb_o,
    output logic                        w_last_o,
    output logic                        w_user_o,
    output logic                        w_valid_o,
    input  logic                        w_ready_i,
    // B channel
    input  logic [AxiIdWidth-1:0]       b_id_i,
    input  logic [1:0]                  b_resp_i,
    input  logic                        b_user_i,
    input  logic                        b_valid_i,
    output logic                        b_ready_o,
    // AR channel
    output logic [AxiIdWidth-1:0]       ar_id_o,
    output logic [AxiAddrWidth-1:0]     ar_addr_o,
    output logic [7:0]                  ar_len_o,
    output logic [2:0]                  ar_size_o,
    output logic [1:0]                  ar_burst_o,
    output logic                        ar_lock_o,
    output logic [3:0]                  ar_cache_o,
    output logic [2:0]                  ar_prot_o,
    output logic [3:0]                  ar_qos_o,
    output logic [3:0]                  ar_region_o,
    output logic                        ar_user_o,
    output logic                        ar_valid_o,
    input  logic                        ar_ready_i,
    // R channel
    input  logic [AxiIdWidth-1:0]       r_id_i,
    input  logic [AxiDataWidth-1:0]     r_data_i,
    input  logic [1:0]                  r_resp_i,
    input  logic                        r_last_i,
    input  logic                        r_user_i,
    input  logic                        r_valid_i,
    output logic                        r_ready_o
);

    localparam int unsigned RegStrbW = RegDataWidth / 8;
    localparam int unsigned AxiStrbW = AxiDataWidth / 8;
    localparam int unsigned NumLanes = AxiDataWidth / RegDataWidth;
    localparam int unsigned RegOffW  = $clog2(RegStrbW);
    localparam int unsigned AxiOffW  = $clog2(AxiStrbW);
    localparam int unsigned LaneW    = (NumLanes > 1) ? (AxiOffW - RegOffW) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_e;

    state_e                    state_q, state_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      error_q, error_d;
    logic [AxiAddrWidth-1:0]   addr_q, addr_d;
    logic [RegDataWidth-1:0]   wdata_q, wdata_d;
    logic [RegStrbW-1:0]       wstrb_q, wstrb_d;
    logic [RegDataWidth-1:0]   rdata_q, rdata_d;
    logic [LaneW-1:0]          lane;
    logic                      aw_hs, w_hs;

    // The ID, user and rlast response fields carry nothing this bridge needs.
    // Only bit 1 of each resp field is used as the error flag.
    logic unused_resp;
    assign unused_resp = ^{b_id_i, b_resp_i[0], b_user_i, r_id_i, r_resp_i[0], r_last_i, r_user_i};

    // The reg word's position inside the wider AXI beat.
    if (NumLanes > 1) begin : g_lane
        assign lane = addr_q[AxiOffW-1:RegOffW];
    end else begin : g_nolane
        assign lane = '0;
    end

    // Both address channels carry the same fixed single-beat attributes.
    assign aw_id_o     = AxiId;
    assign aw_addr_o   = addr_q;
    assign aw_len_o    = 8'd0;
    assign aw_size_o   = 3'(RegOffW);
    assign aw_burst_o  = 2'b01;
    assign aw_lock_o   = 1'b0;
    assign aw_cache_o  = 4'd0;
    assign aw_prot_o   = 3'd0;
    assign aw_qos_o    = 4'd0;
    assign aw_region_o = 4'd0;
    assign aw_atop_o   = 6'd0;
    assign aw_user_o   = 1'b0;

    assign ar_id_o     = AxiId;
    assign ar_addr_o   = addr_q;
    assign ar_len_o    = 8'd0;
    assign ar_size_o   = 3'(RegOffW);
    assign ar_burst_o  = 2'b01;
    assign ar_lock_o   = 1'b0;
    assign ar_cache_o  = 4'd0;
    assign ar_prot_o   = 3'd0;
    assign ar_qos_o    = 4'd0;
    assign ar_region_o = 4'd0;
    assign ar_user_o   = 1'b0;

    // Write data goes out on every lane. The strobe picks the lane the address selects.
    assign w_data_o = {NumLanes{wdata_q}};
    assign w_strb_o = AxiStrbW'(wstrb_q) << (lane * RegStrbW);
    assign w_last_o = 1'b1;
    assign w_user_o = 1'b0;

    assign aw_hs = aw_valid_o && aw_ready_i;
    assign w_hs  = w_valid_o && w_ready_i;

    // Control state: FSM, per-channel handshake flags and the captured error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            error_q   <= error_d;
        end
    end

    // Request and response payload. It is only observed through the FSM, so it needs no reset.
    always_ff @(posedge clk_i) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
        rdata_q <= rdata_d;
    end

    // Next-state logic: sequence the AXI handshakes of one transaction.
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        error_d   = error_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (reg_valid_i) begin
                    addr_d    = reg_addr_i;
                    wdata_d   = reg_wdata_i;
                    wstrb_d   = reg_wstrb_i;
                    rdata_d   = '0;
                    error_d   = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = reg_write_i ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                // AW and W can complete in any order, including the same cycle.
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_valid_i) begin
                    error_d = b_resp_i[1];
                    state_d = DONE;
                end
            end
            RD_ADDR: begin
                if (ar_ready_i) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_valid_i) begin
                    rdata_d = r_data_i[lane*RegDataWidth +: RegDataWidth];
                    error_d = r_resp_i[1];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from registered state only. This keeps every valid independent of its ready.
    always_comb begin
        aw_valid_o  = 1'b0;
        w_valid_o   = 1'b0;
        b_ready_o   = 1'b0;
        ar_valid_o  = 1'b0;
        r_ready_o   = 1'b0;
        reg_ready_o = 1'b0;
        reg_rdata_o = '0;
        reg_error_o = 1'b0;
        unique case (state_q)
            WR_ADDR_DATA: begin
                aw_valid_o = !aw_done_q;
                w_valid_o  = !w_done_q;
            end
            WR_RESP: b_ready_o = 1'b1;
            RD_ADDR: ar_valid_o = 1'b1;
            RD_DATA: r_ready_o = 1'b1;
            DONE: begin
                reg_ready_o = 1'b1;
                reg_rdata_o = rdata_q;
                reg_error_o = error_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_reg_to_axi_master.sv
// Directed bench for reg_to_axi_master. A behavioural AXI slave has per-channel
// stall counts. A transaction-level model predicts every AXI field and every reg response.
module tb_reg_to_axi_master;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] reg_addr_i = '0;
    logic        reg_write_i = 1'b0;
    logic [31:0] reg_wdata_i = '0;
    logic [3:0]  reg_wstrb_i = '0;
    logic        reg_valid_i = 1'b0;
    logic [31:0] reg_rdata_o;
    logic        reg_error_o, reg_ready_o;
    logic [3:0]  aw_id_o, aw_cache_o, aw_qos_o, aw_region_o;
    logic [31:0] aw_addr_o;
    logic [7:0]  aw_len_o;
    logic [2:0]  aw_size_o, aw_prot_o;
    logic [1:0]  aw_burst_o;
    logic [5:0]  aw_atop_o;
    logic        aw_lock_o, aw_user_o, aw_valid_o;
    logic        aw_ready_i = 1'b0;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;
    logic        w_last_o, w_user_o, w_valid_o;
    logic        w_ready_i = 1'b0;
    logic [3:0]  b_id_i = '0;
    logic [1:0]  b_resp_i = '0;
    logic        b_user_i = 1'b0;
    logic        b_valid_i = 1'b0;
    logic        b_ready_o;
    logic [3:0]  ar_id_o, ar_cache_o, ar_qos_o, ar_region_o;
    logic [31:0] ar_addr_o;
    logic [7:0]  ar_len_o;
    logic [2:0]  ar_size_o, ar_prot_o;
    logic [1:0]  ar_burst_o;
    logic        ar_lock_o, ar_user_o, ar_valid_o;
    logic        ar_ready_i = 1'b0;
    logic [3:0]  r_id_i = '0;
    logic [63:0] r_data_i = '0;
    logic [1:0]  r_resp_i = '0;
    logic        r_last_i = 1'b1;
    logic        r_user_i = 1'b0;
    logic        r_valid_i = 1'b0;
    logic        r_ready_o;

    always #5 clk_i = ~clk_i;

    reg_to_axi_master dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .reg_addr_i(reg_addr_i), .reg_write_i(reg_write_i), .reg_wdata_i(reg_wdata_i),
        .reg_wstrb_i(reg_wstrb_i), .reg_valid_i(reg_valid_i),
        .reg_rdata_o(reg_rdata_o), .reg_error_o(reg_error_o), .reg_ready_o(reg_ready_o),
        .aw_id_o(aw_id_o), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o),
        .aw_burst_o(aw_burst_o), .aw_lock_o(aw_lock_o), .aw_cache_o(aw_cache_o), .aw_prot_o(aw_prot_o),
        .aw_qos_o(aw_qos_o), .aw_region_o(aw_region_o), .aw_atop_o(aw_atop_o), .aw_user_o(aw_user_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o), .w_user_o(w_user_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .b_id_i(b_id_i), .b_resp_i(b_resp_i), .b_user_i(b_user_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .ar_id_o(ar_id_o), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
        .ar_burst_o(ar_burst_o), .ar_lock_o(ar_lock_o), .ar_cache_o(ar_cache_o), .ar_prot_o(ar_prot_o),
        .ar_qos_o(ar_qos_o), .ar_region_o(ar_region_o), .ar_user_o(ar_user_o),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .r_id_i(r_id_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_last_i(r_last_i), .r_user_i(r_user_i),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // slave configuration
    int          aw_stall = 0, w_stall = 0, b_stall = 0, ar_stall = 0, r_stall = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [63:0] r_data_cfg = '0;

    // slave / scoreboard state
    int   aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    int   tx_aw = 0, tx_w = 0, tx_ar = 0, aw_stalled = 0;
    bit   b_pend = 0, b_done = 0, r_pend = 0, rst_seen = 1;
    bit   aw_hold = 0, w_hold = 0, ar_hold = 0, ready_prev = 0;
    logic [31:0] last_aw_addr = '0;
    logic [2:0]  last_aw_size = '0;
    logic [7:0]  last_aw_len = '0, last_w_strb = '0;
    logic [63:0] last_w_data = '0;

    // current transaction as issued by the stimulus
    bit          cur_active = 0, cur_write = 0;
    logic [31:0] cur_addr = '0, cur_wdata = '0;
    logic [3:0]  cur_wstrb = '0;
    logic [7:0]  exp_strb;
    logic [31:0] exp_rdata;

    // Slave bookkeeping at the active edge: handshakes, stall counters, response scheduling.
    always begin
        @(posedge clk_i);
        rst_seen = rst_i;
        if (rst_i) begin
            b_pend = 0; r_pend = 0; aw_hold = 0; w_hold = 0; ar_hold = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        end else begin
            aw_hold = aw_valid_o && !aw_ready_i;
            w_hold  = w_valid_o && !w_ready_i;
            ar_hold = ar_valid_o && !ar_ready_i;
            if (b_valid_i && b_ready_o) begin b_pend = 0; b_done = 1; end
            else if (b_pend) b_wait++;
            if (r_valid_i && r_ready_o) r_pend = 0;
            else if (r_pend) r_wait++;
            if (aw_valid_o && aw_ready_i) begin
                tx_aw++; aw_wait = 0;
                last_aw_addr = aw_addr_o; last_aw_size = aw_size_o; last_aw_len = aw_len_o;
            end else if (aw_valid_o) begin
                aw_wait++; aw_stalled++;
            end
            if (w_valid_o && w_ready_i) begin
                tx_w++; w_wait = 0; last_w_strb = w_strb_o; last_w_data = w_data_o;
            end else if (w_valid_o) w_wait++;
            if (ar_valid_o && ar_ready_i) begin
                tx_ar++; ar_wait = 0; r_pend = 1; r_wait = 0;
            end else if (ar_valid_o) ar_wait++;
            if (tx_aw > 0 && tx_w > 0 && !b_done && !b_pend) begin b_pend = 1; b_wait = 0; end
        end
    end

    // Slave drives its readys and responses on the falling edge.
    always begin
        @(negedge clk_i);
        aw_ready_i = aw_valid_o && (aw_wait >= aw_stall);
        w_ready_i  = w_valid_o && (w_wait >= w_stall);
        ar_ready_i = ar_valid_o && (ar_wait >= ar_stall);
        b_valid_i  = b_pend && (b_wait >= b_stall);
        b_resp_i   = b_valid_i ? b_resp_cfg : 2'b00;
        r_valid_i  = r_pend && (r_wait >= r_stall);
        r_data_i   = r_valid_i ? r_data_cfg : 64'd0;
        r_resp_i   = r_valid_i ? r_resp_cfg : 2'b00;
    end

    // Compare process: check the DUT against the transaction model every cycle.
    always begin
        @(posedge clk_i);
        #2;
        exp_strb  = 8'(cur_wstrb) << (4 * cur_addr[2]);
        exp_rdata = 32'(r_data_cfg >> (32 * cur_addr[2]));
        if (rst_seen) begin
            chk("rst_outs", {aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o, reg_ready_o, reg_error_o}, 64'd0);
            chk("rst_rdata", reg_rdata_o, 64'd0);
        end else begin
            if (aw_hold) chk("aw_valid_held", aw_valid_o, 1);
            if (w_hold)  chk("w_valid_held", w_valid_o, 1);
            if (ar_hold) chk("ar_valid_held", ar_valid_o, 1);
            if (aw_valid_o) begin
                chk("aw_addr", aw_addr_o, cur_addr);
                chk("aw_attr", {aw_id_o, aw_len_o, aw_size_o, aw_burst_o}, {4'd0, 8'd0, 3'd2, 2'b01});
                chk("aw_zero", {aw_lock_o, aw_cache_o, aw_prot_o, aw_qos_o, aw_region_o, aw_atop_o, aw_user_o}, 64'd0);
                chk("aw_for_write", cur_write, 1);
                chk("aw_single", tx_aw, 0);
            end
            if (w_valid_o) begin
                chk("w_data", w_data_o, {cur_wdata, cur_wdata});
                chk("w_strb", w_strb_o, exp_strb);
                chk("w_last_user", {w_last_o, w_user_o}, 2'b10);
                chk("w_single", tx_w, 0);
            end
            if (ar_valid_o) begin
                chk("ar_addr", ar_addr_o, cur_addr);
                chk("ar_attr", {ar_id_o, ar_len_o, ar_size_o, ar_burst_o}, {4'd0, 8'd0, 3'd2, 2'b01});
                chk("ar_zero", {ar_lock_o, ar_cache_o, ar_prot_o, ar_qos_o, ar_region_o, ar_user_o}, 64'd0);
                chk("ar_for_read", cur_write, 0);
                chk("ar_single", tx_ar, 0);
            end
            if (b_ready_o) chk("b_after_aw_w", (tx_aw == 1 && tx_w == 1), 1);
            if (r_ready_o) chk("r_after_ar", tx_ar, 1);
            if (reg_ready_o) begin
                chk("ready_expected", cur_active, 1);
                chk("ready_pulse", ready_prev, 0);
                if (cur_write) begin
                    chk("wr_error", reg_error_o, b_resp_cfg[1]);
                    chk("wr_counts", tx_aw * 100 + tx_w * 10 + tx_ar, 110);
                end else begin
                    chk("rd_data", reg_rdata_o, exp_rdata);
                    chk("rd_error", reg_error_o, r_resp_cfg[1]);
                    chk("rd_counts", tx_aw * 100 + tx_w * 10 + tx_ar, 1);
                end
            end
        end
        ready_prev = reg_ready_o;
    end

    task automatic start_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb);
        @(negedge clk_i);
        cur_active = 1; cur_write = wr; cur_addr = addr; cur_wdata = wdata; cur_wstrb = wstrb;
        tx_aw = 0; tx_w = 0; tx_ar = 0; b_done = 0; aw_stalled = 0;
        reg_valid_i = 1'b1; reg_write_i = wr; reg_addr_i = addr;
        reg_wdata_i = wdata; reg_wstrb_i = wstrb;
        @(posedge clk_i);
        @(negedge clk_i);
        reg_valid_i = 1'b0;
    endtask

    // lat counts active edges from the accepting edge to the edge that samples ready.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata, output logic err,
                          output int lat);
        start_txn(wr, addr, wdata, wstrb);
        lat = 1;
        while (!reg_ready_o && lat < 200) begin
            @(negedge clk_i);
            lat++;
        end
        if (!reg_ready_o) chk("ready_timeout", reg_ready_o, 1);
        rdata = reg_rdata_o;
        err   = reg_error_o;
        @(negedge clk_i);
        cur_active = 0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;

        repeat (3) @(negedge clk_i);
        chk("reset_idle", {aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o, reg_ready_o}, 64'd0);
        rst_i = 1'b0;

        // zero-wait write into the upper lane
        do_txn(1, 32'h2000_0004, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        chk("t1_latency", lat, 3);
        chk("t1_error", er, 0);
        chk("t1_aw_addr", last_aw_addr, 32'h2000_0004);
        chk("t1_aw_size_len", {last_aw_size, last_aw_len}, {3'd2, 8'd0});
        chk("t1_w_strb", last_w_strb, 8'hF0);
        chk("t1_w_data", last_w_data, 64'hDEAD_BEEF_DEAD_BEEF);

        // reads from both lanes of the same beat
        r_data_cfg = 64'h1111_2222_3333_4444;
        do_txn(0, 32'h2000_0000, '0, '0, rd, er, lat);
        chk("t2_lo_rdata", rd, 32'h3333_4444);
        chk("t2_lo_error", er, 0);
        chk("t2_lo_latency", lat, 3);
        do_txn(0, 32'h2000_0004, '0, '0, rd, er, lat);
        chk("t2_hi_rdata", rd, 32'h1111_2222);

        // AW stalled 4 cycles, W accepted at once
        aw_stall = 4;
        do_txn(1, 32'h2000_0010, 32'h1234_5678, 4'h3, rd, er, lat);
        chk("t3_aw_stalled", aw_stalled, 4);
        chk("t3_latency", lat, 7);
        chk("t3_w_strb", last_w_strb, 8'h03);
        chk("t3_error", er, 0);
        aw_stall = 0;

        // error responses, each followed by a clean access
        b_resp_cfg = 2'b11;
        do_txn(1, 32'h2000_0008, 32'hA5A5_A5A5, 4'h1, rd, er, lat);
        chk("t4_decerr", er, 1);
        b_resp_cfg = 2'b00;
        do_txn(1, 32'h2000_000C, 32'h5A5A_5A5A, 4'hC, rd, er, lat);
        chk("t4_wr_ok", er, 0);
        chk("t4_w_strb", last_w_strb, 8'hC0);
        r_resp_cfg = 2'b10;
        do_txn(0, 32'h2000_0004, '0, '0, rd, er, lat);
        chk("t4_slverr", er, 1);
        r_resp_cfg = 2'b00;
        do_txn(0, 32'h2000_0004, '0, '0, rd, er, lat);
        chk("t4_rd_ok", er, 0);
        chk("t4_rd_data", rd, 32'h1111_2222);

        // back-pressure on B then on R
        b_stall = 10;
        do_txn(1, 32'h2000_0020, 32'h0BAD_F00D, 4'hF, rd, er, lat);
        chk("t5_b_latency", lat, 13);
        chk("t5_b_error", er, 0);
        b_stall = 0;
        r_stall = 7;
        do_txn(0, 32'h2000_0000, '0, '0, rd, er, lat);
        chk("t5_r_latency", lat, 10);
        chk("t5_r_rdata", rd, 32'h3333_4444);
        r_stall = 0;

        // reset while waiting for R, then a fresh read
        r_stall = 50;
        start_txn(0, 32'h2000_0008, '0, '0);
        n = 0;
        while (!r_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("t6_in_rd_data", r_ready_o, 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("t6_rst_outs", {aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o, reg_ready_o, reg_error_o}, 64'd0);
        chk("t6_rst_rdata", reg_rdata_o, 64'd0);
        rst_i = 1'b0;
        cur_active = 0;
        r_stall = 0;
        r_data_cfg = 64'hCAFE_F00D_0BAD_C0DE;
        do_txn(0, 32'h2000_0008, '0, '0, rd, er, lat);
        chk("t6_rdata", rd, 32'h0BAD_C0DE);
        chk("t6_error", er, 0);
        chk("t6_latency", lat, 3);

        repeat (3) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
